// File: rtl/register_file_multiport_pkg.sv
// Shared types and constants for the multiport register file.
package rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int          RF_DATA_WIDTH = 32;
  localparam int          RF_ADDR_WIDTH = 5;
  localparam logic [31:0] RF_SP_INIT    = 32'h7c;

  // Bit offset of port k inside a packed bus whose fields are width bits wide.
  function automatic int rf_slice(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/register_file_multiport_read_port.sv
// One registered read port: zero-register select, write-first bypass,
// then an output register that only loads while en is high.
module rf_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] entry_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] value;

  // Resolve the read value: hardwired zero beats bypass, bypass beats storage.
  always_comb begin
    value = entry_data;
    if (ZERO_REG != 0 && addr == '0) begin
      value = '0;
    end else if (wr_en && wr_addr == addr) begin
      value = wr_data;
    end
  end

  // Capture the resolved value; hold the previous value when not enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= value;
    end
  end

endmodule

// File: rtl/register_file_multiport.sv
// Parametrised register file with NUM_READ registered read ports, one write
// port, a debug read port and a post-reset init sweep that seeds the stack
// pointer entry.
module register_file_multiport
  import rf_pkg::*;
#(
  parameter int                    DATA_WIDTH = RF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int                    NUM_READ   = 2,
  parameter int                    ZERO_REG   = 1,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(RF_SP_INIT)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           ready,
  input  logic                           dbg_req,
  input  logic [ADDR_WIDTH-1:0]          dbg_addr,
  output logic [DATA_WIDTH-1:0]          dbg_data,
  output logic                           dbg_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The counter is one bit wider than an address so it can reach DEPTH.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_SP   = (ADDR_WIDTH + 1)'(SP_INDEX);

  rf_state_t             state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  run;
  logic                  wr_en_run;
  logic                  dbg_en;

  assign run       = (state == RUN);
  assign wr_en_run = wr_en & run;
  assign dbg_en    = dbg_req & run;

  // Sequencer: sweep every entry once after reset, then stay in RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Storage: sweep writes during INIT, user writes in RUN (entry 0 protected).
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt[ADDR_WIDTH-1:0]] <= (cnt == CNT_SP) ? SP_INIT : '0;
      end else if (wr_en && !(ZERO_REG != 0 && wr_addr == '0)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    localparam int AOFF = rf_slice(k, ADDR_WIDTH);
    localparam int DOFF = rf_slice(k, DATA_WIDTH);
    logic [ADDR_WIDTH-1:0] addr_k;
    assign addr_k = rd_addr[AOFF +: ADDR_WIDTH];

    rf_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG)
    ) u_port (
      .clock     (clock),
      .reset     (reset),
      .en        (run),
      .addr      (addr_k),
      .entry_data(mem[addr_k]),
      .wr_en     (wr_en_run),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .data      (rd_data[DOFF +: DATA_WIDTH])
    );
  end

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_dbg_port (
    .clock     (clock),
    .reset     (reset),
    .en        (dbg_en),
    .addr      (dbg_addr),
    .entry_data(mem[dbg_addr]),
    .wr_en     (wr_en_run),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data      (dbg_data)
  );

  // Debug valid pulses for exactly the cycles whose edge accepted a request.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= dbg_en;
    end
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport, built with four read ports.
module tb_register_file_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             ready;
  logic             dbg_req;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;
  logic             dbg_valid;

  always #5 clock = ~clock;

  register_file_multiport #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_READ  (NR),
    .ZERO_REG  (1),
    .SP_INDEX  (29),
    .SP_INIT   (32'h7c)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ready    (ready),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .dbg_valid(dbg_valid)
  );

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic             dv;
    logic [DW-1:0]    dd;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[10];
  logic [DW-1:0] mm[DEPTH];
  logic [DW-1:0] last_dd;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mm[a];
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    for (int k = 0; k < NR; k++) e.rd[k*DW +: DW] = mval(rd_addr[k*AW +: AW]);
    e.dv = dbg_req;
    e.dd = dbg_req ? mval(dbg_addr) : last_dd;
    return e;
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                              input logic dv, input logic [DW-1:0] dd);
    exp_t e;
    e.rd[0*DW +: DW] = r0;
    e.rd[1*DW +: DW] = r1;
    e.rd[2*DW +: DW] = r1;
    e.rd[3*DW +: DW] = r0;
    e.dv = dv;
    e.dd = dd;
    return e;
  endfunction

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    mm[29] = 32'h7c;
  endfunction

  // Ports 2 and 3 mirror ports 1 and 0 so every port sees the same cases.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic dreq, input logic [AW-1:0] daddr);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr  = {ra0, ra1, ra1, ra0};
    dbg_req  = dreq;
    dbg_addr = daddr;
  endtask

  // One RUN cycle: queue the expectation, clock, commit the write, compare.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clock);
    if (wr_en && wr_addr != '0) mm[wr_addr] = wr_data;
    #1;
    got = sb.pop_front();
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s rd%0d", tag, k), rd_data[k*DW +: DW], got.rd[k*DW +: DW]);
    chk($sformatf("%s dbg_valid", tag), DW'(dbg_valid), DW'(got.dv));
    chk($sformatf("%s dbg_data", tag), dbg_data, got.dd);
    chk($sformatf("%s ready", tag), DW'(ready), 32'd1);
    last_dd = got.dd;
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'h5555_0000, 5'd4, 5'd29, 1'b1, 5'd29);
    @(posedge clock);
    #1;
    chk($sformatf("%s ready", tag), DW'(ready), 32'd0);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s rd%0d", tag, k), rd_data[k*DW +: DW], 32'd0);
    chk($sformatf("%s dbg_valid", tag), DW'(dbg_valid), 32'd0);
    chk($sformatf("%s dbg_data", tag), dbg_data, 32'd0);
    last_dd = '0;
  endtask

  // Full sweep with writes and debug requests held active, all of which must be ignored.
  task automatic sweep_check(input string tag);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd29, 1'b1, 5'd29);
      @(posedge clock);
      #1;
      chk($sformatf("%s ready c%0d", tag, i + 1), DW'(ready), DW'(i == DEPTH - 1));
      chk($sformatf("%s dbg_valid c%0d", tag, i + 1), DW'(dbg_valid), 32'd0);
      chk($sformatf("%s rd0 c%0d", tag, i + 1), rd_data[0 +: DW], 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    model_init();
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd6,  32'h0,        32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 5'd7,  32'h1234,     5'd7,  5'd7,  32'h1234,     32'h1234};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h1234,     32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd29, 32'h0,        32'h7c};
    tbl[6] = '{1'b1, 5'd28, 32'h55,       5'd28, 5'd29, 32'h55,       32'h7c};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd29, 5'd28, 32'h7c,       32'h55};
    tbl[8] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd30, 5'd31, 32'h0,        32'hA5A5A5A5};
    tbl[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd1,  32'hA5A5A5A5, 32'h0};

    last_dd = '0;
    reset_cycle("rst_a");
    reset_cycle("rst_b");
    sweep_check("sweep1");

    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 5'd0, 32'd0, AW'(a), AW'(DEPTH - 1 - a), 1'b1, AW'(a));
      step($sformatf("init a%0d", a), model_exp());
    end

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1, 1'b0, 5'd0);
      step($sformatf("vec%0d", i), mk(tbl[i].e0, tbl[i].e1, 1'b0, last_dd));
    end

    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd29);
    step("dbg 29", mk(32'h0, 32'h0, 1'b1, 32'h7c));
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd5);
    step("dbg 5", mk(32'h0, 32'h0, 1'b1, 32'hDEADBEEF));
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
    step("dbg 0", mk(32'h0, 32'h0, 1'b1, 32'h0));
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7);
    step("dbg 7", mk(32'h0, 32'h0, 1'b1, 32'h1234));
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd5);
    step("dbg idle hold", mk(32'h0, 32'h0, 1'b0, 32'h1234));
    drive(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 1'b1, 5'd9);
    step("dbg bypass", mk(32'h99, 32'h0, 1'b1, 32'h99));
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0, 5'd0);
    step("dbg after", mk(32'h99, 32'h0, 1'b0, 32'h99));

    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31)));
      step($sformatf("rand%0d", i), model_exp());
    end

    reset_cycle("rst_c");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'(i == 5), 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd29, 1'b1, 5'd3);
      @(posedge clock);
      #1;
      chk($sformatf("partial ready c%0d", i + 1), DW'(ready), 32'd0);
      chk($sformatf("partial dbg_valid c%0d", i + 1), DW'(dbg_valid), 32'd0);
    end
    reset_cycle("rst_mid");
    sweep_check("sweep2");

    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b1, 5'd3);
    step("post 3/5", mk(32'h0, 32'h0, 1'b1, 32'h0));
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd28, 1'b1, 5'd29);
    step("post 29/28", mk(32'h7c, 32'h0, 1'b1, 32'h7c));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
